alpha_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single memory request/response channel (`PKT_BITS` packet protocol) between the instruction-fetch side (I) and the load/store side (D). Registers the winning request, forwards it to the memory port, and routes every response beat back to the owning requester. Tracks one outstanding transaction at a time, with a response-timeout watchdog. Sits between the cache/bus front-ends and the BRAM/memory peripheral.

---
 rtl/alpha_mem_pkg.sv | 29 ++
 rtl/alpha_mem_arbiter_if.sv | 24 ++
 rtl/alpha_rr_arb2.sv | 34 +++
 rtl/alpha_mem_arbiter.sv | 82 ++++++++
 tb/tb_alpha_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alpha_mem_pkg.sv
// alpha_mem_pkg: packet field macros, arbiter state/owner types and the final-beat helper.
// Macros: PKT_BITS and the PKT_* field slices, REQ_SZ_* size codes.
`ifndef ALPHA_MEM_DEFINES
`define ALPHA_MEM_DEFINES
`define PKT_BITS 102
`define PKT_VLD 0
`define PKT_LAST 1
`define PKT_CMD 3:2
`define PKT_SIZE 5:4
`define PKT_ADDR 37:6
`define PKT_DATA 101:38
`define REQ_CMD_LOAD 2'd0
`define REQ_CMD_STORE 2'd1
`define REQ_CMD_FETCH 2'd2
`define REQ_SZ_4 2'd0
`define REQ_SZ_8 2'd1
`define REQ_SZ_LINE 2'd2
`endif

package alpha_mem_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
    typedef logic [`PKT_BITS-1:0] pkt_t;

    // Line requests finish on the LAST beat; everything else on its first beat.
    function automatic logic is_final_beat(input pkt_t pkt, input logic line);
        return !line || pkt[`PKT_LAST];
    endfunction
endpackage

// File: rtl/alpha_mem_arbiter_if.sv
// alpha_mem_arbiter_if: request/response channels between the I/D front-ends, the arbiter and memory.
// slave modport: arbiter side (takes ireq/dreq/mem_resp/mem_req_ack, drives acks, resps, mem_req).
// master modport: the surrounding requesters and memory.
interface alpha_mem_arbiter_if;
    import alpha_mem_pkg::*;
    pkt_t ireq_pkt_xx;
    logic ireq_ack_xx;
    pkt_t iresp_pkt_xx;
    pkt_t dreq_pkt_xx;
    logic dreq_ack_xx;
    pkt_t dresp_pkt_xx;
    pkt_t mem_req_pkt_xx;
    logic mem_req_ack_xx;
    pkt_t mem_resp_pkt_xx;

    modport slave (
        input  ireq_pkt_xx, dreq_pkt_xx, mem_req_ack_xx, mem_resp_pkt_xx,
        output ireq_ack_xx, iresp_pkt_xx, dreq_ack_xx, dresp_pkt_xx, mem_req_pkt_xx
    );
    modport master (
        output ireq_pkt_xx, dreq_pkt_xx, mem_req_ack_xx, mem_resp_pkt_xx,
        input  ireq_ack_xx, iresp_pkt_xx, dreq_ack_xx, dresp_pkt_xx, mem_req_pkt_xx
    );
endinterface

// File: rtl/alpha_rr_arb2.sv
// alpha_rr_arb2: two-way pick between I and D from their valids and the last grant.
// Ports: clk, reset_n (sync, active-low); i_vld/d_vld candidates; take = a grant is consumed
// this cycle; grant = any candidate; win = chosen side.
// Config: ALPHA_MEM_ARB_DPRIO_EN selects fixed D-over-I priority (rr_last still tracks grants).
module alpha_rr_arb2
    import alpha_mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_vld,
    input  logic   d_vld,
    input  logic   take,
    output logic   grant,
    output owner_e win
);
    owner_e rr_last;

    always_comb begin
        grant = i_vld | d_vld;
`ifdef ALPHA_MEM_ARB_DPRIO_EN
        win = d_vld ? OWN_D : OWN_I;
`else
        win = (i_vld && d_vld) ? (rr_last == OWN_I ? OWN_D : OWN_I) : (d_vld ? OWN_D : OWN_I);
`endif
    end

    // Reset to D so I wins the very first tie.
    always_ff @(posedge clk) begin
        if (!reset_n)
            rr_last <= OWN_D;
        else if (take && grant)
            rr_last <= win;
    end
endmodule

// File: rtl/alpha_mem_arbiter.sv
// alpha_mem_arbiter: shares one memory request/response channel between I-fetch and load/store.
// Ports: clk; reset_n (sync, active-low); bus (alpha_mem_arbiter_if.slave: ireq/dreq with acks,
// iresp/dresp beats, mem_req with ack, mem_resp); arb_busy (not IDLE); err_timeout (sticky watchdog).
// Params: TIMEOUT_CYC (RESP cycles before abort, 0 = off), CNT_W (watchdog counter width).
// Config: ALPHA_MEM_ARB_DPRIO_EN -> fixed D-over-I arbitration instead of round-robin.
module alpha_mem_arbiter
    import alpha_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    alpha_mem_arbiter_if.slave  bus,
    output logic                arb_busy,
    output logic                err_timeout
);
    arb_state_e       state, state_n;
    pkt_t             req_q, win_pkt;
    owner_e           owner, win;
    logic             final_line, grant, idle, beat, fin, timeout;
    logic [CNT_W-1:0] cnt;

    alpha_rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_vld   (bus.ireq_pkt_xx[`PKT_VLD]),
        .d_vld   (bus.dreq_pkt_xx[`PKT_VLD]),
        .take    (idle),
        .grant   (grant),
        .win     (win)
    );

    always_comb begin
        // Gating with reset_n keeps acks and beats silent while reset is held.
        idle = reset_n && state == ARB_IDLE;
        beat = reset_n && state == ARB_RESP && bus.mem_resp_pkt_xx[`PKT_VLD];
        fin = beat && is_final_beat(bus.mem_resp_pkt_xx, final_line);
        timeout = TIMEOUT_CYC > 0 && state == ARB_RESP && !fin && cnt == CNT_W'(TIMEOUT_CYC - 1);
        win_pkt = win == OWN_D ? bus.dreq_pkt_xx : bus.ireq_pkt_xx;
        bus.ireq_ack_xx = idle && grant && win == OWN_I;
        bus.dreq_ack_xx = idle && grant && win == OWN_D;
        bus.iresp_pkt_xx = (beat && owner == OWN_I) ? bus.mem_resp_pkt_xx : '0;
        bus.dresp_pkt_xx = (beat && owner == OWN_D) ? bus.mem_resp_pkt_xx : '0;
        bus.mem_req_pkt_xx = state == ARB_REQ ? req_q : '0;
        arb_busy = state != ARB_IDLE;
        state_n = state;
        case (state)
            ARB_IDLE: state_n = grant ? ARB_REQ : ARB_IDLE;
            ARB_REQ:  state_n = bus.mem_req_ack_xx ? ARB_RESP : ARB_REQ;
            ARB_RESP: state_n = (fin || timeout) ? ARB_IDLE : ARB_RESP;
            default:  state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ARB_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q       <= '0;
            owner       <= OWN_I;
            final_line  <= 1'b0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (idle && grant) begin
                req_q      <= win_pkt;
                owner      <= win;
                final_line <= win_pkt[`PKT_SIZE] == `REQ_SZ_LINE;
            end
            // Counts RESP cycles; cleared everywhere else so each transaction starts at 0.
            cnt <= state == ARB_RESP ? cnt + 1'b1 : '0;
            if (timeout)
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alpha_mem_arbiter.sv
// tb_alpha_mem_arbiter: directed scoreboard bench for alpha_mem_arbiter (TIMEOUT_CYC=4).
module tb_alpha_mem_arbiter;
    typedef logic [101:0] pkt_t;
    typedef struct {
        bit   side;
        pkt_t pkt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic arb_busy, err_timeout;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_dbeat = -1;
    int   stray_req = 0;
    exp_t exp_q[$];
    pkt_t req_exp[$];
    pkt_t plan_beats[$];
    int   plan_cnt[$];
    bit   grant_log[$];

    alpha_mem_arbiter_if bus();

    alpha_mem_arbiter #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {data, addr, size, cmd, last, vld}
    function automatic pkt_t mk(bit last, logic [1:0] cmd, logic [1:0] size, logic [31:0] addr, logic [63:0] data);
        return {data, addr, size, cmd, last, 1'b1};
    endfunction

    function void chk_pkt(string name, pkt_t act, pkt_t want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endfunction

    function void chk_bit(string name, logic act, logic want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, want);
        end
    endfunction

    function void chk_int(string name, int act, int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endfunction

    function void fail_now(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected completion", name);
    endfunction

    function void beat_chk(bit side, pkt_t p);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: side %0d got %h expected none", side, p);
        end else begin
            e = exp_q.pop_front();
            chk_bit("resp_side", side, e.side);
            chk_pkt("resp_pkt", p, e.pkt);
        end
    endfunction

    function void expect_txn(bit side, pkt_t rq, pkt_t rs);
        exp_t e;
        e.side = side;
        e.pkt = rs;
        req_exp.push_back(rq);
        plan_cnt.push_back(1);
        plan_beats.push_back(rs);
        exp_q.push_back(e);
    endfunction

    // Monitor: every presented response beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (bus.iresp_pkt_xx[0])
            beat_chk(1'b0, bus.iresp_pkt_xx);
        if (bus.dresp_pkt_xx[0]) begin
            beat_chk(1'b1, bus.dresp_pkt_xx);
            last_dbeat = cyc;
        end
    end

    // Memory model: acks in REQ, then plays the planned beats back to back.
    initial begin
        int n;
        int done;
        done = 0;
        bus.mem_req_ack_xx = 1'b0;
        bus.mem_resp_pkt_xx = '0;
        forever begin
            @(negedge clk);
            if (stray_req != done) begin
                done = stray_req;
                @(posedge clk);
                #1 bus.mem_resp_pkt_xx = mk(1'b1, 2'd0, 2'd1, 32'h100, 64'hdead);
                @(posedge clk);
                #1 bus.mem_resp_pkt_xx = '0;
            end else if (bus.mem_req_pkt_xx[0]) begin
                if (req_exp.size() != 0)
                    chk_pkt("mem_req", bus.mem_req_pkt_xx, req_exp.pop_front());
                else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: got %h expected none", bus.mem_req_pkt_xx);
                end
                bus.mem_req_ack_xx = 1'b1;
                @(posedge clk);
                #1 bus.mem_req_ack_xx = 1'b0;
                n = plan_cnt.size() != 0 ? plan_cnt.pop_front() : 0;
                for (int i = 0; i < n; i++) begin
                    bus.mem_resp_pkt_xx = plan_beats.pop_front();
                    @(posedge clk);
                    #1;
                end
                bus.mem_resp_pkt_xx = '0;
            end
        end
    end

    task automatic req(input bit side, input pkt_t p, output int ack_cyc);
        bit got;
        got = 1'b0;
        ack_cyc = -1;
        if (side) bus.dreq_pkt_xx = p;
        else bus.ireq_pkt_xx = p;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = side ? bus.dreq_ack_xx : bus.ireq_ack_xx;
            if (got) begin
                grant_log.push_back(side);
                ack_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (side) bus.dreq_pkt_xx = '0;
        else bus.ireq_pkt_xx = '0;
        if (!got) fail_now(side ? "dreq_ack_wait" : "ireq_ack_wait");
    endtask

    task automatic drain();
        int c;
        for (c = 0; c < 100 && (exp_q.size() != 0 || arb_busy); c++) @(negedge clk);
        if (c == 100) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int a, ai, ad, t0;
        pkt_t p, q;
        bit [3:0] order;
        bus.ireq_pkt_xx = '0;
        bus.dreq_pkt_xx = '0;
        // Reset state, with both requesters already valid.
        repeat (2) @(posedge clk);
        #1;
        bus.ireq_pkt_xx = mk(1'b0, 2'd0, 2'd1, 32'h10, 64'h0);
        bus.dreq_pkt_xx = mk(1'b0, 2'd0, 2'd1, 32'h20, 64'h0);
        @(negedge clk);
        chk_bit("rst_iack", bus.ireq_ack_xx, 1'b0);
        chk_bit("rst_dack", bus.dreq_ack_xx, 1'b0);
        chk_bit("rst_busy", arb_busy, 1'b0);
        chk_bit("rst_err", err_timeout, 1'b0);
        chk_bit("rst_memreq_vld", bus.mem_req_pkt_xx[0], 1'b0);
        @(posedge clk);
        #1;
        bus.ireq_pkt_xx = '0;
        bus.dreq_pkt_xx = '0;
        reset_n = 1'b1;

        // Single I load, ack same cycle as valid.
        p = mk(1'b0, 2'd0, 2'd1, 32'h100, 64'h0);
        expect_txn(1'b0, p, mk(1'b1, 2'd0, 2'd1, 32'h100, 64'h1122334455667788));
        t0 = cyc;
        req(1'b0, p, a);
        chk_int("t1_ack_cyc", a, t0);
        drain();
        chk_bit("t1_idle", arb_busy, 1'b0);

        // Fresh reset, then two rounds of simultaneous traffic.
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        grant_log.delete();
`ifdef ALPHA_MEM_ARB_DPRIO_EN
        expect_txn(1'b1, mk(1'b0, 2'd0, 2'd1, 32'h1200, 0), mk(1'b1, 2'd0, 2'd1, 32'h1200, 64'hd1));
        expect_txn(1'b0, mk(1'b0, 2'd0, 2'd1, 32'h1100, 0), mk(1'b1, 2'd0, 2'd1, 32'h1100, 64'ha1));
        expect_txn(1'b1, mk(1'b0, 2'd0, 2'd1, 32'h1208, 0), mk(1'b1, 2'd0, 2'd1, 32'h1208, 64'hd2));
        expect_txn(1'b0, mk(1'b0, 2'd0, 2'd1, 32'h1108, 0), mk(1'b1, 2'd0, 2'd1, 32'h1108, 64'ha2));
`else
        expect_txn(1'b0, mk(1'b0, 2'd0, 2'd1, 32'h1100, 0), mk(1'b1, 2'd0, 2'd1, 32'h1100, 64'ha1));
        expect_txn(1'b1, mk(1'b0, 2'd0, 2'd1, 32'h1200, 0), mk(1'b1, 2'd0, 2'd1, 32'h1200, 64'hd1));
        expect_txn(1'b0, mk(1'b0, 2'd0, 2'd1, 32'h1108, 0), mk(1'b1, 2'd0, 2'd1, 32'h1108, 64'ha2));
        expect_txn(1'b1, mk(1'b0, 2'd0, 2'd1, 32'h1208, 0), mk(1'b1, 2'd0, 2'd1, 32'h1208, 64'hd2));
`endif
        fork
            req(1'b0, mk(1'b0, 2'd0, 2'd1, 32'h1100, 0), ai);
            req(1'b1, mk(1'b0, 2'd0, 2'd1, 32'h1200, 0), ad);
        join
        fork
            req(1'b0, mk(1'b0, 2'd0, 2'd1, 32'h1108, 0), ai);
            req(1'b1, mk(1'b0, 2'd0, 2'd1, 32'h1208, 0), ad);
        join
        drain();
        chk_int("t2_grants", grant_log.size(), 4);
        order = 4'b0;
        for (int i = 0; i < 4 && i < grant_log.size(); i++) order[3-i] = grant_log[i];
`ifdef ALPHA_MEM_ARB_DPRIO_EN
        chk_int("t2_order", int'(order), 4'b1010);
`else
        chk_int("t2_order", int'(order), 4'b0101);
`endif

        // D line fetch: two beats, IDLE only after LAST.
        p = mk(1'b0, 2'd2, 2'd2, 32'h2008, 64'h0);
        req_exp.push_back(p);
        plan_cnt.push_back(2);
        plan_beats.push_back(mk(1'b0, 2'd2, 2'd2, 32'h2008, 64'h0123456789abcdef));
        plan_beats.push_back(mk(1'b1, 2'd2, 2'd2, 32'h2008, 64'hfedcba9876543210));
        exp_q.push_back('{1'b1, mk(1'b0, 2'd2, 2'd2, 32'h2008, 64'h0123456789abcdef)});
        exp_q.push_back('{1'b1, mk(1'b1, 2'd2, 2'd2, 32'h2008, 64'hfedcba9876543210)});
        req(1'b1, p, a);
        at_cyc(a + 3);
        chk_bit("t3_busy_mid_line", arb_busy, 1'b1);
        at_cyc(a + 4);
        chk_bit("t3_idle_after_last", arb_busy, 1'b0);
        drain();

        // D store, I queued behind it: I acked the cycle after the store beat.
        p = mk(1'b0, 2'd1, 2'd0, 32'h40, 64'haabb);
        q = mk(1'b0, 2'd0, 2'd1, 32'h180, 64'h0);
        expect_txn(1'b1, p, mk(1'b1, 2'd1, 2'd0, 32'h40, 64'haabb));
        expect_txn(1'b0, q, mk(1'b1, 2'd0, 2'd1, 32'h180, 64'h55));
        fork
            req(1'b1, p, ad);
            begin
                @(posedge clk);
                #1;
                req(1'b0, q, ai);
            end
        join
        chk_int("t4_back_to_back", ai, last_dbeat + 1);
        chk_int("t4_ack_gap", ai, ad + 3);
        drain();

        // Watchdog: silent memory, abort after 4 RESP cycles.
        p = mk(1'b0, 2'd0, 2'd1, 32'h300, 64'h0);
        req_exp.push_back(p);
        plan_cnt.push_back(0);
        req(1'b0, p, a);
        at_cyc(a + 5);
        chk_bit("t5_busy_last_resp", arb_busy, 1'b1);
        chk_bit("t5_err_before", err_timeout, 1'b0);
        at_cyc(a + 6);
        chk_bit("t5_idle_after_wd", arb_busy, 1'b0);
        chk_bit("t5_err_set", err_timeout, 1'b1);
        stray_req++;
        repeat (4) @(negedge clk);
        chk_bit("t5_err_sticky", err_timeout, 1'b1);
        chk_bit("t5_stray_idle", arb_busy, 1'b0);

        // Reset mid-RESP.
        @(posedge clk);
        #1;
        p = mk(1'b0, 2'd0, 2'd1, 32'h400, 64'h0);
        req_exp.push_back(p);
        plan_cnt.push_back(0);
        req(1'b0, p, a);
        at_cyc(a + 3);
        chk_bit("t6_in_resp", arb_busy, 1'b1);
        chk_bit("t6_err_still", err_timeout, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_bit("t6_busy_clr", arb_busy, 1'b0);
        chk_bit("t6_err_clr", err_timeout, 1'b0);
        chk_bit("t6_memreq_vld", bus.mem_req_pkt_xx[0], 1'b0);
        repeat (6) @(negedge clk);
        chk_bit("t6_err_stays_clr", err_timeout, 1'b0);
        chk_int("t6_no_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
